interrupt_controller: RTL and testbench

- Upstream feeder of the multicycle MIPS Controller's interrupt inputs. Collects NUM_IRQ maskable request lines and one non-maskable line.
- Drives INT, NMI and INTD to the Controller. Consumes the Controller's isInterrupted/INA acknowledge pair.
- Provides a latched vector number of the serviced source for the handler-address logic.
- Tracks in-service state until the handler signals return (eret).

---
 rtl/interrupt_controller.sv | 180 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller feeding the Controller's INT/NMI inputs, with NMI nesting and a latched vector.
// Macro INTC_EDGE_DETECT_EN selects edge capture; without it requests track the lines as levels.
//
// state   | meaning
// IDLE    | no handler running
// INT_SVC | maskable handler running, INTD held
// NMI_SVC | NMI handler running
// NESTED  | NMI handler preempted a maskable handler
module interrupt_controller #(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 VEC_W      = 3,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmiIn,
    input  logic               maskWrite,
    input  logic [NUM_IRQ-1:0] maskData,
    input  logic               eret,
    input  logic               isInterrupted,
    input  logic               INA,
    output logic               INT,
    output logic               NMI,
    output logic               INTD,
    output logic [VEC_W-1:0]   vector,
    output logic               intActive,
    output logic               nmiActive
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        INT_SVC = 2'b01,
        NMI_SVC = 2'b10,
        NESTED  = 2'b11
    } state_t;

    state_t             state;
    state_t             state_after_eret;
    state_t             state_next;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] req;
    logic               nmi_pending;
    logic               ack_prev;
    logic               ack;
    logic               take_int;
    logic               take_nmi;
    logic               int_active;
    logic               nmi_active;
    logic [VEC_W-1:0]   sel;

    assign req = pending & mask;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = VEC_W'(i);
            end
        end
    end

    assign ack      = isInterrupted & ~ack_prev;
    assign take_int = ack & INA & INT;
    assign take_nmi = ack & ~INA & NMI;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_prev <= 1'b0;
            mask     <= MASK_RESET;
        end else begin
            ack_prev <= isInterrupted;
            if (maskWrite) begin
                mask <= maskData;
            end
        end
    end

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] irq_prev;
    logic               nmi_prev;
    logic [NUM_IRQ-1:0] clr;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = take_int & req[i] & (sel == VEC_W'(i));
        end
    end

    // A fresh edge on the source being acknowledged keeps it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev    <= '0;
            nmi_prev    <= 1'b0;
            pending     <= '0;
            nmi_pending <= 1'b0;
        end else begin
            irq_prev    <= irq;
            nmi_prev    <= nmiIn;
            pending     <= (pending & ~clr) | (irq & ~irq_prev);
            nmi_pending <= (nmi_pending & ~take_nmi) | (nmiIn & ~nmi_prev);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            nmi_pending <= 1'b0;
        end else begin
            pending     <= irq;
            nmi_pending <= nmiIn;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Return is applied before any acknowledge arriving in the same cycle.
    always_comb begin
        state_after_eret = state;
        state_next       = state;
        int_active       = 1'b0;
        nmi_active       = 1'b0;

        if (eret) begin
            case (state)
                INT_SVC: state_after_eret = IDLE;
                NMI_SVC: state_after_eret = IDLE;
                NESTED:  state_after_eret = INT_SVC;
                default: state_after_eret = state;
            endcase
        end

        state_next = state_after_eret;
        if (take_int) begin
            case (state_after_eret)
                IDLE:    state_next = INT_SVC;
                NMI_SVC: state_next = NESTED;
                default: state_next = state_after_eret;
            endcase
        end else if (take_nmi) begin
            case (state_after_eret)
                IDLE:    state_next = NMI_SVC;
                INT_SVC: state_next = NESTED;
                default: state_next = state_after_eret;
            endcase
        end

        int_active = (state == INT_SVC) || (state == NESTED);
        nmi_active = (state == NMI_SVC) || (state == NESTED);
    end

    assign intActive = int_active;
    assign nmiActive = nmi_active;
    assign INTD      = int_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            INT    <= 1'b0;
            NMI    <= 1'b0;
            vector <= '0;
        end else begin
            INT <= (|req) & ~int_active & ~nmi_active;
            NMI <= nmi_pending & ~nmi_active;
            if (take_int) begin
                vector <= sel;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the request/service rules.
module tb_interrupt_controller;

    localparam int N  = 8;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          nmi_in;
    logic          mask_write;
    logic [N-1:0]  mask_data;
    logic          eret;
    logic          is_int;
    logic          ina;
    logic          int_req;
    logic          nmi_req;
    logic          intd;
    logic [VW-1:0] vector;
    logic          int_active;
    logic          nmi_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ(N),
        .VEC_W(VW),
        .MASK_RESET({N{1'b1}})
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
        .nmiIn(nmi_in),
        .maskWrite(mask_write),
        .maskData(mask_data),
        .eret(eret),
        .isInterrupted(is_int),
        .INA(ina),
        .INT(int_req),
        .NMI(nmi_req),
        .INTD(intd),
        .vector(vector),
        .intActive(int_active),
        .nmiActive(nmi_active)
    );

    // Behavioural model: per-source flags, handler nesting as two flags.
    bit m_pend[N];
    bit m_mask[N];
    bit m_prev[N];
    bit m_nmi_pend;
    bit m_nmi_prev;
    bit m_ack_prev;
    bit m_int;
    bit m_nmi;
    bit m_ia;
    bit m_na;
    int m_vec;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_mask[i] = 1;
            m_prev[i] = 0;
        end
        m_nmi_pend = 0;
        m_nmi_prev = 0;
        m_ack_prev = 0;
        m_int = 0;
        m_nmi = 0;
        m_ia = 0;
        m_na = 0;
        m_vec = 0;
    endfunction

    function automatic void model_step();
        bit ack_now;
        bit take_i;
        bit take_n;
        bit new_int;
        bit new_nmi;
        int sel;
        sel = -1;
        for (int i = 0; i < N; i++)
            if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
        ack_now = (is_int === 1'b1) && !m_ack_prev;
        take_i  = ack_now && (ina === 1'b1) && m_int;
        take_n  = ack_now && (ina === 1'b0) && m_nmi;
        new_int = (sel >= 0) && !m_ia && !m_na;
        new_nmi = m_nmi_pend && !m_na;
        if (eret === 1'b1) begin
            if (m_na) m_na = 0;
            else if (m_ia) m_ia = 0;
        end
        if (take_i) begin
            m_ia  = 1;
            m_vec = (sel < 0) ? 0 : sel;
        end
        if (take_n) m_na = 1;
`ifdef INTC_EDGE_DETECT_EN
        for (int i = 0; i < N; i++) begin
            m_pend[i] = (m_pend[i] && !(take_i && i == sel)) || (irq[i] === 1'b1 && !m_prev[i]);
            m_prev[i] = (irq[i] === 1'b1);
        end
        m_nmi_pend = (m_nmi_pend && !take_n) || (nmi_in === 1'b1 && !m_nmi_prev);
        m_nmi_prev = (nmi_in === 1'b1);
`else
        for (int i = 0; i < N; i++) m_pend[i] = (irq[i] === 1'b1);
        m_nmi_pend = (nmi_in === 1'b1);
`endif
        if (mask_write === 1'b1)
            for (int i = 0; i < N; i++) m_mask[i] = (mask_data[i] === 1'b1);
        m_ack_prev = (is_int === 1'b1);
        m_int = new_int;
        m_nmi = new_nmi;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = '0; nmi_in = 0; mask_write = 0; mask_data = '0;
        eret = 0; is_int = 0; ina = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({int_req, nmi_req, intd, int_active, nmi_active} !== 5'b0 || vector !== '0) begin
            errors++;
            $display("FAIL reset_state: outs=%b vector=%0d, want 00000 / 0",
                     {int_req, nmi_req, intd, int_active, nmi_active}, vector);
        end
        // enter service with NMI requested, then reset mid-cycle
        irq = 8'h01; step(); step();
        is_int = 1; ina = 1; step();
        nmi_in = 1; step(); step();
        checks++;
        if (intd !== 1'b1 || nmi_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_service: intd=%b nmi=%b, want 1 1", intd, nmi_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({int_req, nmi_req, intd, int_active, nmi_active} !== 5'b0 || vector !== '0) begin
            errors++;
            $display("FAIL async_reset: outs=%b vector=%0d, want 00000 / 0",
                     {int_req, nmi_req, intd, int_active, nmi_active}, vector);
        end
        model_reset();
        irq = '0; nmi_in = 0; is_int = 0; ina = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(); step();
        checks++;
        if ({int_req, nmi_req, intd, int_active, nmi_active} !== 5'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: outs=%b, want 00000",
                     {int_req, nmi_req, intd, int_active, nmi_active});
        end
    endtask

    task automatic test_eret_idle();
        eret = 1; step(); eret = 0;
        checks++;
        if (intd !== 1'b0 || int_active !== 1'b0 || nmi_active !== 1'b0) begin
            errors++;
            $display("FAIL eret_idle: intd=%b ia=%b na=%b, want 0 0 0", intd, int_active, nmi_active);
        end
        is_int = 1; ina = 1; step();
        checks++;
        if (int_active !== 1'b0 || intd !== 1'b0) begin
            errors++;
            $display("FAIL ack_without_int: ia=%b intd=%b, want 0 0", int_active, intd);
        end
        is_int = 0; step();
    endtask

    task automatic test_priority_ack();
        irq = 8'b0010_0100; step(); step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL prio_int_raise: INT=%b, want 1", int_req);
        end
        is_int = 1; ina = 1; step();
        checks++;
        if (vector !== 3'd2 || intd !== 1'b1) begin
            errors++; $display("FAIL prio_first: vector=%0d intd=%b, want 2 1", vector, intd);
        end
        irq = 8'b0010_0000; is_int = 0; step();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL prio_int_drop: INT=%b, want 0", int_req);
        end
        eret = 1; step(); eret = 0;
        checks++;
        if (intd !== 1'b0) begin
            errors++; $display("FAIL prio_eret: intd=%b, want 0", intd);
        end
        step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL prio_reraise: INT=%b, want 1", int_req);
        end
        is_int = 1; step();
        checks++;
        if (vector !== 3'd5) begin
            errors++; $display("FAIL prio_second: vector=%0d, want 5", vector);
        end
        irq = '0; is_int = 0; eret = 1; step(); eret = 0; step(); step();
    endtask

    task automatic test_masking();
        mask_write = 1; mask_data = 8'hFB; step(); mask_write = 0;
        irq = 8'h04;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (int_req !== 1'b0) begin
                errors++; $display("FAIL masked_hold cycle %0d: INT=%b, want 0", c, int_req);
            end
        end
        mask_write = 1; mask_data = 8'hFF; step(); mask_write = 0;
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL unmask_same_edge: INT=%b, want 0", int_req);
        end
        step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL unmask_next: INT=%b, want 1", int_req);
        end
        is_int = 1; ina = 1; step();
        checks++;
        if (vector !== 3'd2) begin
            errors++; $display("FAIL unmask_vector: vector=%0d, want 2", vector);
        end
        irq = '0; is_int = 0; eret = 1; step(); eret = 0; step(); step();
    endtask

    task automatic test_nmi_preempt();
        irq = 8'h10; step(); step();
        is_int = 1; ina = 1; step();
        irq = '0; is_int = 0; nmi_in = 1; step(); step();
        checks++;
        if (nmi_req !== 1'b1 || intd !== 1'b1) begin
            errors++; $display("FAIL nmi_raise: NMI=%b intd=%b, want 1 1", nmi_req, intd);
        end
        is_int = 1; ina = 0; step();
        checks++;
        if (nmi_active !== 1'b1 || int_active !== 1'b1) begin
            errors++; $display("FAIL nmi_nested: na=%b ia=%b, want 1 1", nmi_active, int_active);
        end
        nmi_in = 0; is_int = 0; step();
        checks++;
        if (nmi_req !== 1'b0) begin
            errors++; $display("FAIL nmi_drop: NMI=%b, want 0", nmi_req);
        end
        eret = 1; step(); eret = 0;
        checks++;
        if (nmi_active !== 1'b0 || intd !== 1'b1 || vector !== 3'd4) begin
            errors++;
            $display("FAIL nmi_first_eret: na=%b intd=%b vector=%0d, want 0 1 4", nmi_active, intd, vector);
        end
        step(); eret = 1; step(); eret = 0;
        checks++;
        if (intd !== 1'b0 || int_active !== 1'b0) begin
            errors++; $display("FAIL nmi_second_eret: intd=%b ia=%b, want 0 0", intd, int_active);
        end
        step(); step();
        checks++;
        if (int_req !== 1'b0 || nmi_req !== 1'b0) begin
            errors++; $display("FAIL nmi_quiet: INT=%b NMI=%b, want 0 0", int_req, nmi_req);
        end
    endtask

`ifdef INTC_EDGE_DETECT_EN
    task automatic test_collision();
        irq = 8'h08; step();
        irq = '0; step();
        irq = 8'h08; is_int = 1; ina = 1; step();
        checks++;
        if (vector !== 3'd3 || intd !== 1'b1) begin
            errors++; $display("FAIL coll_ack: vector=%0d intd=%b, want 3 1", vector, intd);
        end
        is_int = 0; irq = '0; step(); step();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL coll_blocked: INT=%b, want 0", int_req);
        end
        eret = 1; step(); eret = 0; step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL coll_still_pending: INT=%b, want 1", int_req);
        end
        is_int = 1; step();
        checks++;
        if (vector !== 3'd3) begin
            errors++; $display("FAIL coll_vector: vector=%0d, want 3", vector);
        end
        is_int = 0; eret = 1; step(); eret = 0; step(); step();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL coll_cleared: INT=%b, want 0", int_req);
        end
    endtask
`else
    task automatic test_level();
        irq = 8'h02; step(); step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL level_raise: INT=%b, want 1", int_req);
        end
        is_int = 1; ina = 1; step();
        checks++;
        if (vector !== 3'd1 || intd !== 1'b1) begin
            errors++; $display("FAIL level_ack: vector=%0d intd=%b, want 1 1", vector, intd);
        end
        is_int = 0; step(); step();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL level_blocked: INT=%b, want 0", int_req);
        end
        eret = 1; step(); eret = 0; step();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL level_reraise: INT=%b, want 1", int_req);
        end
        irq = '0; step(); step();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL level_drop: INT=%b, want 0", int_req);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(15) == 0) irq[i] = ~irq[i];
            if ($urandom_range(31) == 0) nmi_in = ~nmi_in;
            mask_write = ($urandom_range(19) == 0);
            mask_data  = N'($urandom);
            eret       = ($urandom_range(11) == 0);
            if ($urandom_range(3) == 0) begin
                is_int = ~is_int;
                ina    = $urandom_range(1);
            end
            step();
            checks++;
            if (int_req !== m_int || nmi_req !== m_nmi || intd !== m_ia || int_active !== m_ia ||
                nmi_active !== m_na || vector !== VW'(m_vec)) begin
                errors++;
                $display("FAIL random cycle %0d: INT/NMI/INTD/ia/na=%b%b%b%b%b vec=%0d, want %b%b%b%b%b vec=%0d",
                         c, int_req, nmi_req, intd, int_active, nmi_active, vector,
                         m_int, m_nmi, m_ia, m_ia, m_na, m_vec);
            end
        end
        irq = '0; nmi_in = 0; mask_write = 0; eret = 0; is_int = 0;
    endtask

    initial begin
        test_reset();
        test_eret_idle();
        test_priority_ack();
        test_masking();
        test_nmi_preempt();
`ifdef INTC_EDGE_DETECT_EN
        test_collision();
`else
        test_level();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
